result_ascii_sender: RTL and testbench

//  Downstream of the ALU, upstream of uart_tx. Captures the 8-bit ALU result on request and

---
 rtl/result_sender_pkg.sv | 33 +++
 rtl/hex_ascii_enc.sv | 19 +
 rtl/result_ascii_sender.sv | 169 ++++++++++++++++
 tb/tb_result_ascii_sender.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/result_sender_pkg.sv
// Shared types, ASCII constants and the nibble-to-character helper for the result sender.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package result_sender_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_BUSY,
    WAIT_DONE,
    NEXT
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 map onto '0'..'9'; 10-15 map onto 'A'..'F' or 'a'..'f'.
  // The letter base is pre-biased by -10 so one adder serves both ranges.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib, input logic upper);
    logic [7:0] base;
    if (nib < 4'd10) begin
      base = ASCII_0;
    end else begin
      base = (upper ? ASCII_A : ASCII_LA) - 8'd10;
    end
    return base + {4'h0, nib};
  endfunction

endpackage

// File: rtl/hex_ascii_enc.sv
// Combinational hex nibble to ASCII character encoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   i_nib   : 4-bit nibble to encode
//   i_upper : 1 selects 'A'-'F', 0 selects 'a'-'f'
//   o_char  : 8-bit ASCII character
module hex_ascii_enc
  import result_sender_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_upper,
  output logic [7:0] o_char
);

  assign o_char = nib2ascii(i_nib, i_upper);

endmodule

// File: rtl/result_ascii_sender.sv
// Captures an ALU result on request and streams it to uart_tx as ASCII hex, MS nibble first.
// Latency: request accepted at cycle 0 gives the first tx_start at cycle 2; done one cycle after the last tx_busy fall.
// Backpressure: one byte in flight; waits for tx_busy to rise then fall (or a rise timeout) before the next byte.
//
// Ports:
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_send_req, i_result     : capture request (honoured only in IDLE) and the value to send
//   i_tx_busy                : busy flag from uart_tx
//   o_tx_start, o_tx_data    : one-cycle enable strobe and byte to uart_tx
//   o_busy, o_done, o_overrun: message in progress, end-of-message pulse, sticky ignored-request flag
//
// Build option: define RESULT_TX_CRLF_EN to append CR, LF after the hex characters.
module result_ascii_sender
  import result_sender_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int BUSY_WAIT_MAX = 15,
  parameter int UPPERCASE     = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_send_req,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_tx_busy,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam int NIB = DATA_W / 4;
`ifdef RESULT_TX_CRLF_EN
  localparam int LAST = NIB + 1;
`else
  localparam int LAST = NIB - 1;
`endif
  localparam int IDX_W = (LAST > 0) ? $clog2(LAST + 1) : 1;
  localparam int WC_W  = (BUSY_WAIT_MAX > 0) ? $clog2(BUSY_WAIT_MAX + 1) : 1;

  state_t            r_state;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic              r_busy;
  logic              r_done;
  logic              r_overrun;
  logic [IDX_W-1:0]  r_idx;
  logic [WC_W-1:0]   r_wcnt;
  logic [DATA_W-1:0] r_shadow;

  logic [3:0] w_nib;
  logic [7:0] w_hex;
  logic [7:0] w_char;
  logic       w_last;
  logic       w_upper;

  assign w_upper = (UPPERCASE != 0);
  assign w_last  = (r_idx == IDX_W'(LAST));

  // Pick the nibble addressed by r_idx; index 0 is the most significant nibble.
  always_comb begin
    w_nib = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib = r_shadow[DATA_W-1-4*k -: 4];
      end
    end
  end

  hex_ascii_enc u_enc (
    .i_nib   (w_nib),
    .i_upper (w_upper),
    .o_char  (w_hex)
  );

  // Indices past the hex characters carry the line terminator.
  always_comb begin
    w_char = w_hex;
`ifdef RESULT_TX_CRLF_EN
    if (r_idx == IDX_W'(NIB)) begin
      w_char = ASCII_CR;
    end else if (r_idx == IDX_W'(NIB + 1)) begin
      w_char = ASCII_LF;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_shadow   <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;

      // Requests arriving mid-message are dropped but remembered.
      if (i_send_req && r_busy) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (i_send_req) begin
            r_shadow  <= i_result;
            r_idx     <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          // tx_start is registered, so it is raised here to be high during STROBE.
          r_tx_data  <= w_char;
          r_tx_start <= 1'b1;
          r_state    <= STROBE;
        end
        STROBE: begin
          r_wcnt  <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_wcnt == WC_W'(BUSY_WAIT_MAX)) begin
            // Transmitter never acknowledged; treat the byte as sent.
            r_done  <= w_last;
            r_state <= NEXT;
          end else begin
            r_wcnt <= r_wcnt + WC_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            // done is registered, so it is raised here to be high during NEXT.
            r_done  <= w_last;
            r_state <= NEXT;
          end
        end
        NEXT: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= LOAD;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_result_ascii_sender.sv
// Bench for result_ascii_sender: two instances (upper/lower case) share stimulus and a uart busy model.
// Latency: n/a.
// Backpressure: uart model holds tx_busy for blen cycles per strobe, or ties it low.
module tb_result_ascii_sender;

  localparam int DATA_W = 8;
  localparam int NIB    = DATA_W / 4;
  localparam int BWM    = 15;

  logic              clk;
  logic              reset;
  logic              send_req;
  logic [DATA_W-1:0] result;
  logic              tx_busy;
  logic              tx_start_w [2];
  logic [7:0]        tx_data_w  [2];
  logic              busy_w     [2];
  logic              done_w     [2];
  logic              ovr_w      [2];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // uart model controls
  int mode = 0;   // 0: busy for blen cycles per strobe, 1: tied low
  int blen = 10;
  int bcnt = 0;

  // scoreboard
  logic [7:0] got0[$], got1[$], exp0[$], exp1[$];
  int scyc0[$];
  int dones0, dones1;
  int done_cyc0;

  result_ascii_sender #(.DATA_W(DATA_W), .BUSY_WAIT_MAX(BWM), .UPPERCASE(1)) dut_u (
    .i_clk(clk), .i_reset(reset), .i_send_req(send_req), .i_result(result), .i_tx_busy(tx_busy),
    .o_tx_start(tx_start_w[0]), .o_tx_data(tx_data_w[0]), .o_busy(busy_w[0]),
    .o_done(done_w[0]), .o_overrun(ovr_w[0])
  );

  result_ascii_sender #(.DATA_W(DATA_W), .BUSY_WAIT_MAX(BWM), .UPPERCASE(0)) dut_l (
    .i_clk(clk), .i_reset(reset), .i_send_req(send_req), .i_result(result), .i_tx_busy(tx_busy),
    .o_tx_start(tx_start_w[1]), .o_tx_data(tx_data_w[1]), .o_busy(busy_w[1]),
    .o_done(done_w[1]), .o_overrun(ovr_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus uart busy model, all on the falling edge.
  always @(negedge clk) begin
    if (tx_start_w[0]) begin
      got0.push_back(tx_data_w[0]);
      scyc0.push_back(cyc);
    end
    if (tx_start_w[1]) got1.push_back(tx_data_w[1]);
    if (done_w[0]) begin
      dones0 = dones0 + 1;
      done_cyc0 = cyc;
    end
    if (done_w[1]) dones1 = dones1 + 1;
    if (tx_start_w[0]) bcnt = blen;
    else if (bcnt > 0) bcnt = bcnt - 1;
    tx_busy = (mode == 0) && (bcnt > 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_char(input int n, input bit up);
    if (n < 10) return 8'(48 + n);
    return 8'((up ? 65 : 97) + n - 10);
  endfunction

  // Expected message: hex chars MS nibble first, optional CR LF.
  task automatic add_exp(input logic [DATA_W-1:0] v);
    int n;
    for (int k = 0; k < NIB; k++) begin
      n = (int'(v) >> (4 * (NIB - 1 - k))) & 15;
      exp0.push_back(ref_char(n, 1'b1));
      exp1.push_back(ref_char(n, 1'b0));
    end
`ifdef RESULT_TX_CRLF_EN
    exp0.push_back(8'h0D); exp0.push_back(8'h0A);
    exp1.push_back(8'h0D); exp1.push_back(8'h0A);
`endif
  endtask

  task automatic clear_sb();
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete(); scyc0.delete();
    dones0 = 0; dones1 = 0; done_cyc0 = 0;
  endtask

  task automatic compare_sb(input int n_done);
    chk("nbytes_u", got0.size(), exp0.size());
    chk("nbytes_l", got1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) chk("byte_u", got0[i], exp0[i]);
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) chk("byte_l", got1[i], exp1[i]);
    chk("ndone_u", dones0, n_done);
    chk("ndone_l", dones1, n_done);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_w[0]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_start_w[0]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_msg(input logic [DATA_W-1:0] v, input bit inject);
    bit ok;
    clear_sb();
    @(negedge clk);
    result = v; send_req = 1'b1; add_exp(v);
    @(negedge clk);
    send_req = 1'b0;
    result = DATA_W'($urandom);
    chk("acc_busy", busy_w[0], 1);
    chk("acc_no_strobe", tx_start_w[0], 0);
    chk("acc_ovr_clr", ovr_w[0], 0);
    @(negedge clk);
    chk("lat_strobe", tx_start_w[0], 1);
    if (inject) begin
      repeat (4) @(negedge clk);
      result = 8'h55; send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
      chk("ovr_set", ovr_w[0], 1);
      chk("ovr_set_l", ovr_w[1], 1);
    end
    wait_done(ok);
    chk("done_seen", ok, 1);
    @(negedge clk);
    chk("busy_low", busy_w[0], 0);
    chk("done_pulse", done_w[0], 0);
    if (scyc0.size() > 0)
      chk("done_gap", done_cyc0 - scyc0[scyc0.size()-1], (mode == 0) ? blen + 1 : BWM + 2);
    if (mode == 1 && scyc0.size() > 1)
      chk("strobe_gap", scyc0[1] - scyc0[0], BWM + 4);
    @(negedge clk);
    compare_sb(1);
  endtask

  initial begin
    bit ok;
    logic [DATA_W-1:0] v;
    reset = 1'b1; send_req = 1'b0; result = '0; tx_busy = 1'b0;
    clear_sb();
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start_w[0], 0);
    chk("rst_tx_data", tx_data_w[0], 8'h00);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_ovr", ovr_w[0], 0);
    reset = 1'b0;
    @(negedge clk);

    // T1: basic 3F
    mode = 0; blen = 10;
    send_msg(8'h3F, 1'b0);

    // T2: A0 on both case variants
    send_msg(8'hA0, 1'b0);

    // T3: request and result change mid-message; overrun sticks until next accept
    send_msg(8'hC7, 1'b1);
    chk("ovr_sticky", ovr_w[0], 1);
    send_msg(8'h12, 1'b0);

    // T4: tx_busy tied low, timeout path
    mode = 1;
    send_msg(8'hE9, 1'b0);
    mode = 0;

    // Randomized messages with random uart busy length
    for (int r = 0; r < 6; r++) begin
      blen = $urandom_range(12, 2);
      v = DATA_W'($urandom);
      send_msg(v, 1'b0);
    end
    blen = 10;

    // T5: reset during WAIT_DONE of byte 0
    clear_sb();
    @(negedge clk);
    result = 8'hB4; send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    wait_strobe(ok);
    chk("t5_strobe", ok, 1);
    repeat (3) @(negedge clk);
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    chk("t5_ovr", ovr_w[0], 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_tx_start", tx_start_w[0], 0);
    chk("t5_tx_data", tx_data_w[0], 8'h00);
    chk("t5_busy", busy_w[0], 0);
    chk("t5_done", done_w[0], 0);
    chk("t5_ovr_clr", ovr_w[0], 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_nstrobes", got0.size(), 1);
    chk("t5_busy_after", busy_w[0], 0);
    chk("t5_ndone", dones0, 0);

    // T6: send_req held high; each message captures the value present at its accept
    clear_sb();
    @(negedge clk);
    v = DATA_W'($urandom);
    result = v; send_req = 1'b1; add_exp(v);
    for (int m = 0; m < 3; m++) begin
      wait_strobe(ok);
      chk("t6_strobe", ok, 1);
      if (m < 2) begin
        v = DATA_W'($urandom);
        result = v; add_exp(v);
      end
      chk("t6_ovr_busy", ovr_w[0], 1);
      wait_done(ok);
      chk("t6_done", ok, 1);
      if (m == 2) send_req = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("t6_idle", busy_w[0], 0);
    compare_sb(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
